// File: rtl/lock_input_conditioner_if.sv
// Raw board inputs and conditioned lock-core outputs of the lock input conditioner.
// The board side (master) drives the raw levels; the conditioner (slave) drives the clean ones.
interface lock_input_conditioner_if;
   logic       sw_mode_raw;
   logic       btn_next_raw;
   logic       btn_reset_raw;
   logic       btn_finish_raw;
   logic [7:0] sw_number_raw;
   logic [3:0] control_signal;
   logic [7:0] input_number;
   logic [1:0] entry_count;
   logic       entry_full;

   modport master (
      output sw_mode_raw, btn_next_raw, btn_reset_raw, btn_finish_raw, sw_number_raw,
      input  control_signal, input_number, entry_count, entry_full
   );

   modport slave (
      input  sw_mode_raw, btn_next_raw, btn_reset_raw, btn_finish_raw, sw_number_raw,
      output control_signal, input_number, entry_count, entry_full
   );
endinterface

// File: rtl/lock_input_conditioner.sv
// Synchronises and debounces the lock's raw switches/buttons and produces the
// control_signal/input_number levels plus a saturating byte-entry count.
module lock_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int PASSWORD_LENGTH = 3
) (
   input logic                      clk,
   input logic                      rst,
   lock_input_conditioner_if.slave  bus
);
   localparam int             CW        = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]     COUNT_MAX = 2'(PASSWORD_LENGTH);

   // Control bit order: [3] mode, [2] next, [1] reset, [0] finish.
   logic [3:0]    w_ctl_raw;
   logic [3:0]    r_ctl_s1, r_ctl_s2, r_ctl_stable;
   logic [CW-1:0] r_ctl_cnt [4];

   logic [7:0]    r_num_s1, r_num_s2, r_num_stable;
   logic [CW-1:0] r_num_cnt;

   logic       r_mode, r_reset, r_finish, r_next_q, r_toggle;
   logic [7:0] r_number;
   logic [1:0] r_count;

   logic w_next_rise, w_full, w_accept, w_clear;

   assign w_ctl_raw = {bus.sw_mode_raw, bus.btn_next_raw, bus.btn_reset_raw, bus.btn_finish_raw};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctl_s1     <= '0;
         r_ctl_s2     <= '0;
         r_ctl_stable <= '0;
         for (int i = 0; i < 4; i++) r_ctl_cnt[i] <= '0;
      end else begin
         r_ctl_s1 <= w_ctl_raw;
         r_ctl_s2 <= r_ctl_s1;
         for (int i = 0; i < 4; i++) begin
            if (r_ctl_s2[i] == r_ctl_stable[i]) begin
               r_ctl_cnt[i] <= '0;
            end else if (r_ctl_cnt[i] == CNT_LAST) begin
               r_ctl_stable[i] <= r_ctl_s2[i];
               r_ctl_cnt[i]    <= '0;
            end else begin
               r_ctl_cnt[i] <= r_ctl_cnt[i] + 1'b1;
            end
         end
      end
   end

   // The number vector shares one counter; any movement of the synced value restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_num_s1     <= '0;
         r_num_s2     <= '0;
         r_num_stable <= '0;
         r_num_cnt    <= '0;
      end else begin
         r_num_s1 <= bus.sw_number_raw;
         r_num_s2 <= r_num_s1;
         if (r_num_s2 == r_num_stable || r_num_s1 != r_num_s2) begin
            r_num_cnt <= '0;
         end else if (r_num_cnt == CNT_LAST) begin
            r_num_stable <= r_num_s2;
            r_num_cnt    <= '0;
         end else begin
            r_num_cnt <= r_num_cnt + 1'b1;
         end
      end
   end

   // Edges are taken against the registered copies, so they line up with the output stage.
   assign w_next_rise = r_ctl_stable[2] & ~r_next_q;
   assign w_full      = (r_count == COUNT_MAX);
   assign w_accept    = w_next_rise & ~r_ctl_stable[1] & ~w_full;
   assign w_clear     = r_ctl_stable[1] | (r_ctl_stable[3] ^ r_mode) | (r_ctl_stable[0] & ~r_finish);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode   <= 1'b0;
         r_reset  <= 1'b0;
         r_finish <= 1'b0;
         r_next_q <= 1'b0;
         r_toggle <= 1'b0;
         r_number <= '0;
         r_count  <= '0;
      end else begin
         r_mode   <= r_ctl_stable[3];
         r_reset  <= r_ctl_stable[1];
         r_finish <= r_ctl_stable[0];
         r_next_q <= r_ctl_stable[2];
         if (w_clear) begin
            r_count <= '0;
         end else if (w_accept) begin
            r_count  <= r_count + 1'b1;
            r_toggle <= ~r_toggle;
            r_number <= r_num_stable;
         end
      end
   end

   assign bus.control_signal = {r_mode, r_toggle, r_reset, r_finish};
   assign bus.input_number   = r_number;
   assign bus.entry_count    = r_count;
   assign bus.entry_full     = w_full;
endmodule

// File: tb/tb_lock_input_conditioner.sv
// Directed bench for lock_input_conditioner: latency, bounce rejection, entry counting and clears.
module tb_lock_input_conditioner;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   lock_input_conditioner_if bus ();

   lock_input_conditioner #(.DEBOUNCE_CYCLES(20), .PASSWORD_LENGTH(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic press_next(input logic [7:0] sw);
      bus.sw_number_raw = sw;
      tick(25);
      bus.btn_next_raw = 1'b1;
      tick(25);
      bus.btn_next_raw = 1'b0;
      tick(25);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // 1: reset with raw inputs high, then next held across release
      rst = 1'b1;
      bus.sw_mode_raw    = 1'b1;
      bus.btn_next_raw   = 1'b1;
      bus.btn_reset_raw  = 1'b1;
      bus.btn_finish_raw = 1'b1;
      bus.sw_number_raw  = 8'hFF;
      tick(2);
      check_eq("rst_ctrl",  32'(bus.control_signal), 32'h0);
      check_eq("rst_num",   32'(bus.input_number),   32'h0);
      check_eq("rst_count", 32'(bus.entry_count),    32'h0);
      check_eq("rst_full",  32'(bus.entry_full),     32'h0);
      rst = 1'b0;
      bus.sw_mode_raw    = 1'b0;
      bus.btn_reset_raw  = 1'b0;
      bus.btn_finish_raw = 1'b0;
      bus.sw_number_raw  = 8'h5A;
      tick(22);
      check_eq("t1_pre_ctrl", 32'(bus.control_signal), 32'h0);
      tick(1);
      check_eq("t1_ctrl",  32'(bus.control_signal), 32'b0100);
      check_eq("t1_count", 32'(bus.entry_count),    32'd1);
      check_eq("t1_num",   32'(bus.input_number),   32'h5A);
      bus.btn_next_raw = 1'b0;
      tick(25);

      // 2: bouncing next, then held; one toggle 23 clk after the final edge
      bus.sw_number_raw = 8'hCC;
      tick(25);
      for (int i = 0; i < 4; i++) begin
         bus.btn_next_raw = ~bus.btn_next_raw;
         tick(3);
      end
      bus.btn_next_raw = 1'b1;
      tick(22);
      check_eq("t2_pre_tog", 32'(bus.control_signal[2]), 32'd1);
      tick(1);
      check_eq("t2_tog",   32'(bus.control_signal[2]), 32'd0);
      check_eq("t2_num",   32'(bus.input_number),      32'hCC);
      check_eq("t2_count", 32'(bus.entry_count),       32'd2);
      bus.btn_next_raw = 1'b0;
      tick(25);
      check_eq("t2_one_tog", 32'(bus.control_signal[2]), 32'd0);

      // finish press clears the count
      bus.btn_finish_raw = 1'b1;
      tick(25);
      check_eq("fin_lvl",   32'(bus.control_signal[0]), 32'd1);
      check_eq("fin_count", 32'(bus.entry_count),       32'd0);
      bus.btn_finish_raw = 1'b0;
      tick(25);

      // 3: three bytes fill the entry, a fourth is ignored
      press_next(8'hCC);
      check_eq("t3_tog1", 32'(bus.control_signal[2]), 32'd1);
      press_next(8'hAA);
      check_eq("t3_tog2", 32'(bus.control_signal[2]), 32'd0);
      check_eq("t3_num2", 32'(bus.input_number),      32'hAA);
      press_next(8'h11);
      check_eq("t3_tog3",  32'(bus.control_signal[2]), 32'd1);
      check_eq("t3_num3",  32'(bus.input_number),      32'h11);
      check_eq("t3_count", 32'(bus.entry_count),       32'd3);
      check_eq("t3_full",  32'(bus.entry_full),        32'd1);
      press_next(8'h22);
      check_eq("t3_tog4",   32'(bus.control_signal[2]), 32'd1);
      check_eq("t3_num4",   32'(bus.input_number),      32'h11);
      check_eq("t3_count4", 32'(bus.entry_count),       32'd3);

      // 4: reset button held blocks presses and clears the count
      bus.btn_reset_raw = 1'b1;
      tick(22);
      check_eq("t4_pre_rst", 32'(bus.control_signal[1]), 32'd0);
      tick(1);
      check_eq("t4_rst",   32'(bus.control_signal[1]), 32'd1);
      check_eq("t4_count", 32'(bus.entry_count),       32'd0);
      check_eq("t4_full",  32'(bus.entry_full),        32'd0);
      bus.btn_next_raw = 1'b1;
      tick(25);
      bus.btn_next_raw = 1'b0;
      tick(25);
      check_eq("t4_tog", 32'(bus.control_signal[2]), 32'd1);
      bus.btn_reset_raw = 1'b0;
      tick(25);
      check_eq("t4_ctrl", 32'(bus.control_signal), 32'b0100);

      // 5: short mode pulse rejected, held mode accepted and clears the count
      press_next(8'h33);
      check_eq("t5_count0", 32'(bus.entry_count), 32'd1);
      bus.sw_mode_raw = 1'b1;
      tick(19);
      bus.sw_mode_raw = 1'b0;
      tick(30);
      check_eq("t5_short", 32'(bus.control_signal[3]), 32'd0);
      check_eq("t5_count1", 32'(bus.entry_count),      32'd1);
      bus.sw_mode_raw = 1'b1;
      tick(22);
      check_eq("t5_pre_mode", 32'(bus.control_signal[3]), 32'd0);
      tick(1);
      check_eq("t5_mode",   32'(bus.control_signal[3]), 32'd1);
      check_eq("t5_count2", 32'(bus.entry_count),       32'd0);
      bus.sw_mode_raw = 1'b0;
      tick(25);

      // 6: rst mid-debounce, button still held at release
      bus.sw_number_raw = 8'h77;
      tick(25);
      bus.btn_next_raw = 1'b1;
      tick(10);
      rst = 1'b1;
      tick(2);
      check_eq("t6_rst_ctrl", 32'(bus.control_signal), 32'h0);
      check_eq("t6_rst_num",  32'(bus.input_number),   32'h0);
      check_eq("t6_rst_cnt",  32'(bus.entry_count),    32'h0);
      rst = 1'b0;
      tick(22);
      check_eq("t6_pre_ctrl", 32'(bus.control_signal), 32'h0);
      tick(1);
      check_eq("t6_ctrl",  32'(bus.control_signal), 32'b0100);
      check_eq("t6_num",   32'(bus.input_number),   32'h77);
      check_eq("t6_count", 32'(bus.entry_count),    32'd1);
      bus.btn_next_raw = 1'b0;
      tick(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
